// File: rtl/io_tx_buffer_if.sv
// CPU write-bus and UART byte-handshake signals of io_tx_buffer.
// The slave modport is the buffer; the master modport is the CPU/UART side.
interface io_tx_buffer_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    input  io_buffer_full, tx_valid, tx_data
  );

  modport slave (
    input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    output io_buffer_full, tx_valid, tx_data
  );
endinterface

// File: rtl/io_tx_buffer.sv
// Memory-mapped byte FIFO feeding a UART, with a drain-then-NUL program-stop sequence.
// Optional macro IO_TX_FILTER_NUL_EN: CPU pushes of 8'h00 are discarded.
module io_tx_buffer #(
  parameter int DEPTH_BIT   = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  io_tx_buffer_if.slave bus,
  output logic          halted,
  output logic          ovf
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] COUNT_FULL = (DEPTH_BIT + 1)'(DEPTH);
  localparam logic [DEPTH_BIT:0] COUNT_HIGH = (DEPTH_BIT + 1)'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {ST_SEND, ST_DRAIN, ST_NUL, ST_HALT} state_e;

  state_e               state_q, state_d;
  logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BIT:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           mem_q [DEPTH];

  logic sel_io, push_req, stop_req, push_ok, pop;
  logic fifo_full, fifo_empty, fifo_side;
  logic unused_addr_bits;

  // Only bits 17:16 and 2 take part in the decode.
  assign sel_io           = bus.rdy_in & bus.mem_wr & (bus.mem_a[17:16] == 2'b11);
  assign stop_req         = sel_io & bus.mem_a[2];
  assign unused_addr_bits = ^{bus.mem_a[31:18], bus.mem_a[15:3], bus.mem_a[1:0]};
`ifdef IO_TX_FILTER_NUL_EN
  assign push_req = sel_io & ~bus.mem_a[2] & (bus.mem_dout != 8'h00);
`else
  assign push_req = sel_io & ~bus.mem_a[2];
`endif

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign fifo_side  = (state_q == ST_SEND) || (state_q == ST_DRAIN);
  assign pop        = fifo_side & ~fifo_empty & bus.tx_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign push_ok    = push_req & (state_q == ST_SEND) & (~fifo_full | pop);

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_SEND;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it was written.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.mem_dout;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    if (push_req && (state_q == ST_SEND) && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SEND:  if (stop_req)     state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty)   state_d = ST_NUL;
      ST_NUL:   if (bus.tx_ready) state_d = ST_HALT;
      ST_HALT:                    state_d = ST_HALT;
    endcase
  end

  always_comb begin
    bus.tx_valid       = 1'b0;
    bus.tx_data        = 8'h00;
    bus.io_buffer_full = 1'b1;
    halted             = 1'b0;
    unique case (state_q)
      ST_SEND, ST_DRAIN: begin
        bus.tx_valid = ~fifo_empty;
        bus.tx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
        if (state_q == ST_SEND) bus.io_buffer_full = (count_q >= COUNT_HIGH);
      end
      ST_NUL:  bus.tx_valid = 1'b1;
      ST_HALT: halted       = 1'b1;
    endcase
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_io_tx_buffer.sv
// Randomized scoreboard bench for io_tx_buffer: a queue-level model predicts
// accepted bytes and status flags; a monitor checks every emitted byte.
module tb_io_tx_buffer;
  localparam int          DEPTH_BIT   = 3;
  localparam int          FULL_MARGIN = 2;
  localparam int          DEPTH       = 1 << DEPTH_BIT;
  localparam logic [31:0] A_PUSH      = 32'h0003_0000;
  localparam logic [31:0] A_STOP      = 32'h0003_0004;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic halted, ovf;

  io_tx_buffer_if bus ();

  io_tx_buffer #(.DEPTH_BIT(DEPTH_BIT), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus),
    .halted (halted),
    .ovf    (ovf)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the phase of the stop sequence.
  typedef enum {P_SEND, P_DRAIN, P_NUL, P_HALT} phase_e;
  logic [7:0] m_fifo[$];
  logic [7:0] sb_q[$];
  bit         m_ovf;
  phase_e     m_phase;

  task automatic model_clear();
    m_fifo.delete();
    sb_q.delete();
    m_ovf   = 1'b0;
    m_phase = P_SEND;
  endtask

  // Mid-cycle: check the present outputs, then advance the model to the coming edge.
  always @(negedge clk_in) begin : model
    bit exp_valid, exp_full, push, stop;
    if (rst_in) begin
      exp_valid = (m_phase == P_SEND || m_phase == P_DRAIN) ? (m_fifo.size() != 0)
                                                              : (m_phase == P_NUL);
      exp_full  = (m_phase != P_SEND) || (m_fifo.size() >= DEPTH - FULL_MARGIN);
      check("tx_valid", bus.tx_valid, exp_valid);
      check("io_buffer_full", bus.io_buffer_full, exp_full);
      check("ovf", ovf, m_ovf);
      check("halted", halted, m_phase == P_HALT);

      push = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:16] == 2'b11) && !bus.mem_a[2];
      stop = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:16] == 2'b11) &&  bus.mem_a[2];
`ifdef IO_TX_FILTER_NUL_EN
      if (bus.mem_dout == 8'h00) push = 1'b0;
`endif
      case (m_phase)
        P_SEND: begin
          if (m_fifo.size() != 0 && bus.tx_ready) void'(m_fifo.pop_front());
          if (push) begin
            if (m_fifo.size() < DEPTH) begin
              m_fifo.push_back(bus.mem_dout);
              sb_q.push_back(bus.mem_dout);
            end else begin
              m_ovf = 1'b1;
            end
          end
          if (stop) m_phase = P_DRAIN;
        end
        P_DRAIN: begin
          if (m_fifo.size() == 0) begin
            m_phase = P_NUL;
            sb_q.push_back(8'h00);
          end else if (bus.tx_ready) begin
            void'(m_fifo.pop_front());
          end
        end
        P_NUL:   if (bus.tx_ready) m_phase = P_HALT;
        default: ;
      endcase
    end
  end

  // Monitor: every completed handshake must match the oldest expected byte.
  always @(negedge clk_in) begin
    if (rst_in && bus.tx_valid && bus.tx_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte at t=%0t", bus.tx_data, $time);
      end else begin
        check("tx_data", bus.tx_data, sb_q.pop_front());
      end
    end
  end

  task automatic idle();
    bus.rdy_in   = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h0;
    bus.mem_dout = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in   = 1'b1;
    bus.mem_wr   = 1'b1;
    bus.mem_a    = a;
    bus.mem_dout = d;
    cycles(1);
    idle();
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic reset_checks();
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_full", bus.io_buffer_full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after the next edges.
  task automatic apply_reset();
    #2;
    rst_in = 1'b0;
    model_clear();
    #1;
    reset_checks();
    idle();
    cycles(2);
    rst_in = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n;
    idle();
    bus.tx_ready = 1'b0;
    model_clear();
    #1;
    reset_checks();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Single byte, one-cycle latency, popped at once.
    bus.tx_ready = 1'b1;
    bus_write(A_PUSH, 8'h41);
    check("latency_valid", bus.tx_valid, 1'b1);
    check("latency_data", bus.tx_data, 8'h41);
    cycles(2);

    // Fill against a stalled UART: high-water mark, full, overflow, ordered drain.
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) bus_write(A_PUSH, 8'(i));
    check("full_after_6", bus.io_buffer_full, 1'b1);
    bus_write(A_PUSH, 8'h07);
    bus_write(A_PUSH, 8'h08);
    check("ovf_before_9th", ovf, 1'b0);
    bus_write(A_PUSH, 8'h09);
    check("ovf_after_9th", ovf, 1'b1);
    bus.tx_ready = 1'b1;
    wait_drained(40);

    // Push into a full FIFO while popping: accepted and emitted last.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(A_PUSH, 8'h80 + 8'(i));
    bus.tx_ready = 1'b1;
    bus_write(A_PUSH, 8'h55);
    wait_drained(40);

    // NUL byte push: filtered or queued depending on build.
    bus_write(A_PUSH, 8'h00);
    bus_write(A_PUSH, 8'h41);
    wait_drained(40);

    // Randomized traffic: decoded pushes, aliased and foreign addresses, reads, stalls.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel          = $urandom_range(0, 9);
      bus.tx_ready = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.rdy_in   = ($urandom_range(0, 7) != 0);
      bus.mem_wr   = (sel < 8) && ($urandom_range(0, 5) != 0);
      bus.mem_dout = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
      if (sel < 5)      bus.mem_a = A_PUSH;
      else if (sel < 7) bus.mem_a = ($urandom() & 32'hFFFC_FFFF) | 32'h0001_0000;
      else              bus.mem_a = ($urandom() & 32'hFFFF_FFFB) | 32'h0003_0000;
      cycles(1);
    end
    idle();
    bus.tx_ready = 1'b1;
    wait_drained(40);

    // Stop sequence: drain, NUL terminator, halt; later traffic ignored.
    apply_reset();
    bus.tx_ready = 1'b0;
    bus_write(A_PUSH, 8'h31);
    bus_write(A_PUSH, 8'h32);
    bus_write(A_STOP, 8'h00);
    bus_write(A_PUSH, 8'h99);
    bus.tx_ready = 1'b1;
    n = 0;
    while (!halted && n < 50) begin
      cycles(1);
      n++;
    end
    check("halt_reached", halted, 1'b1);
    bus_write(A_PUSH, 8'h77);
    bus_write(A_STOP, 8'h00);
    cycles(3);
    check("halt_sticky", halted, 1'b1);
    check("halt_no_bytes", sb_q.size(), 0);

    // Reset mid-handshake with three bytes buffered: nothing stale afterwards.
    apply_reset();
    bus.tx_ready = 1'b0;
    bus_write(A_PUSH, 8'hA1);
    bus_write(A_PUSH, 8'hA2);
    bus_write(A_PUSH, 8'hA3);
    bus.tx_ready = 1'b1;
    apply_reset();
    cycles(5);
    bus_write(A_PUSH, 8'h5A);
    wait_drained(20);
    cycles(2);
    check("end_scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_tx_buffer.md
IO_TX_BUFFER -- requirements
Module: io_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH_BIT, default 3, giving FIFO depth 2^DEPTH_BIT = 8 byte entries.
REQ-002 SHALL have parameter FULL_MARGIN, default 2, giving the free-entry reserve kept for CPU writes already in flight.
REQ-003 SHALL have port clk_in, input, width 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_in, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port rdy_in, input, width 1: CPU ready; bus writes are sampled only when it is 1.
REQ-006 SHALL have port mem_a, input, width 32: CPU address bus.
REQ-007 SHALL have port mem_dout, input, width 8: CPU write data.
REQ-008 SHALL have port mem_wr, input, width 1: CPU write strobe (1 = write).
REQ-009 SHALL have port io_buffer_full, output, width 1: backpressure to the CPU.
REQ-010 SHALL have port tx_valid, output, width 1: a byte is offered to the UART.
REQ-011 SHALL have port tx_data, output, width 8: the byte offered to the UART.
REQ-012 SHALL have port tx_ready, input, width 1: the UART accepts the offered byte.
REQ-013 SHALL have port halted, output, width 1: the program-stop sequence has completed.
REQ-014 SHALL have port ovf, output, width 1: sticky flag, a push was dropped.

Function
REQ-015 SHALL decode a push when rdy_in=1, mem_wr=1, mem_a[17:16]=2'b11 and mem_a[2]=0 (address 0x30000).
REQ-016 SHALL decode a stop request when rdy_in=1, mem_wr=1, mem_a[17:16]=2'b11 and mem_a[2]=1 (address 0x30004).
REQ-017 SHALL ignore all other accesses, including every read.
REQ-018 SHALL, on a push while not full, write mem_dout at the write pointer, increment the write pointer modulo depth, and increment count.
REQ-019 SHALL keep count DEPTH_BIT+1 bits wide; full is count == 2^DEPTH_BIT and empty is count == 0.
REQ-020 SHALL, on a push while full and with no pop in the same cycle, drop the byte and set ovf, which stays set until reset.
REQ-021 SHALL accept a push and a pop in the same cycle, including when full, leaving count unchanged.
REQ-022 SHALL drive tx_valid=1 and tx_data = the head entry whenever the state is SEND and the FIFO is non-empty.
REQ-023 SHALL give a minimum latency of 1 cycle: a push at edge N makes tx_valid=1 after edge N.
REQ-024 SHALL pop the head entry only on a cycle where tx_valid=1 and tx_ready=1.
REQ-025 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-026 SHALL drive io_buffer_full = (count >= 2^DEPTH_BIT - FULL_MARGIN), or 1 whenever the state is DRAIN, NUL or HALT.
REQ-027 SHALL implement the states SEND, DRAIN, NUL and HALT; the state after reset is SEND.
REQ-028 SHALL move SEND->DRAIN on a stop request; a push and a stop request in the same cycle are impossible, since the address decodes are disjoint.
REQ-029 SHALL, in DRAIN, keep popping entries via the handshake and ignore any new pushes.
REQ-030 SHALL move DRAIN->NUL when count == 0.
REQ-031 SHALL, in NUL, drive tx_valid=1 and tx_data=8'h00, and move to HALT on tx_ready=1.
REQ-032 SHALL, in HALT, drive halted=1 and tx_valid=0, and ignore all bus traffic until reset.
REQ-033 SHALL let the TX side progress independently of rdy_in.

Reset
REQ-034 SHALL, while rst_in=0, immediately clear the pointers, count, ovf and the state (to SEND), and drive tx_valid=0, tx_data=8'h00, halted=0 and io_buffer_full=0.
REQ-035 SHALL, on reset asserted mid-transfer, discard all buffered bytes with no partial handshake afterward.
REQ-036 SHALL leave FIFO storage contents uninitialised, since they are never observable while empty.

Configuration
REQ-037 SHALL provide the macro IO_TX_FILTER_NUL_EN.
REQ-038 SHALL, when IO_TX_FILTER_NUL_EN is defined, treat a push with mem_dout=8'h00 as no operation, so that no entry is written and ovf is unaffected.
REQ-039 SHALL, when IO_TX_FILTER_NUL_EN is undefined, enqueue 8'h00 pushes like any other byte.
REQ-040 SHALL leave the terminating NUL of the stop sequence unaffected by IO_TX_FILTER_NUL_EN.

Verification
REQ-041 SHALL cover this scenario: push 'A'(0x41) to 0x30000 with tx_ready=1 -> tx_valid=1, tx_data=0x41 on the next cycle, popped the same cycle.
REQ-042 SHALL cover this scenario: tx_ready=0, push 0x01..0x06 -> io_buffer_full=1 after the 6th push; 2 more pushes fill the FIFO; a 9th push sets ovf=1; then tx_ready=1 -> output 0x01..0x08 in order.
REQ-043 SHALL cover this scenario: full FIFO with tx_ready=1, push 0x55 -> accepted, count stays 8, and 0x55 is emitted last.
REQ-044 SHALL cover this scenario: push 0x31,0x32, then write to 0x30004 -> output 0x31,0x32,0x00, then halted=1, and later pushes are ignored.
REQ-045 SHALL cover this scenario: with IO_TX_FILTER_NUL_EN defined, push 0x00 then 0x41 -> only 0x41 is emitted; with it undefined -> 0x00 then 0x41 are emitted.
REQ-046 SHALL cover this scenario: with 3 bytes buffered, pulse rst_in=0 mid-handshake -> tx_valid=0 and count=0 immediately, and no stale byte appears after reset is released.
